// File: rtl/timer_pkg.sv
// Shared types and constants for the minute/second countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0] SEC_MAX = 6'd59;

    // Preset seconds above 59 are treated as 59.
    function automatic logic [5:0] clamp_sec(input logic [5:0] sec);
        return (sec > SEC_MAX) ? SEC_MAX : sec;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// One-second prescaler: pulses tick once every CLKS_PER_SEC enabled cycles.
module timer_tick_gen #(
    parameter int unsigned CLKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = en && (cnt_q == LAST);
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer.sv
// Countdown timer: loads M:S on START, counts down once per second tick,
// and flags TIME_UP when 0:00 is reached, holding there until the next START.
module timer
    import timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 1
) (
    input  logic       SYSCLK,
    input  logic       RST_B,
    input  logic [2:0] TIME_MIN,
    input  logic [5:0] TIME_SEC,
    input  logic       START,
    output logic [2:0] MINUTE,
    output logic [5:0] SECOND,
    output logic       TIME_UP
);

    state_e     state_q, state_d;
    logic [2:0] minute_q, minute_d;
    logic [5:0] second_q, second_d;
    logic       time_up_q, time_up_d;
    logic       tick;

    timer_tick_gen #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_tick_gen (
        .clk (SYSCLK),
        .rst (RST_B),
        .clr (START),
        .en  (state_q == RUN),
        .tick(tick)
    );

    // START wins over everything, including a tick landing on the same edge.
    always_comb begin
        state_d   = state_q;
        minute_d  = minute_q;
        second_d  = second_q;
        time_up_d = time_up_q;

        if (START) begin
            minute_d  = TIME_MIN;
            second_d  = clamp_sec(TIME_SEC);
            time_up_d = 1'b0;
            state_d   = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        if (second_q != 6'd0) begin
                            second_d = second_q - 6'd1;
                            if (minute_q == 3'd0 && second_q == 6'd1) begin
                                time_up_d = 1'b1;
                                state_d   = DONE;
                            end
                        end else if (minute_q != 3'd0) begin
                            minute_d = minute_q - 3'd1;
                            second_d = SEC_MAX;
                        end else begin
                            time_up_d = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    minute_d  = 3'd0;
                    second_d  = 6'd0;
                    time_up_d = 1'b1;
                end
                default: begin
                    time_up_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge RST_B) begin
        if (RST_B) begin
            state_q   <= IDLE;
            minute_q  <= 3'd0;
            second_q  <= 6'd0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            minute_q  <= minute_d;
            second_q  <= second_d;
            time_up_q <= time_up_d;
        end
    end

    assign MINUTE  = minute_q;
    assign SECOND  = second_q;
    assign TIME_UP = time_up_q;

endmodule

// File: tb/tb_timer.sv
// Testbench for timer: vector table plus hand sequences, checked through a scoreboard queue.
module tb_timer;
    import timer_pkg::*;

    typedef struct {
        logic       rst;
        logic       start;
        logic [2:0] tmin;
        logic [5:0] tsec;
        int         edges;
        logic [2:0] exp_min;
        logic [5:0] exp_sec;
        logic       exp_up;
    } vec_t;

    typedef struct {
        string      name;
        int         sel;
        logic [2:0] m;
        logic [5:0] s;
        logic       up;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] tmin = 3'd0;
    logic [5:0] tsec = 6'd0;
    logic [2:0] minute;
    logic [5:0] second;
    logic       time_up;

    logic       start4 = 1'b0;
    logic [2:0] tmin4 = 3'd0;
    logic [5:0] tsec4 = 6'd0;
    logic [2:0] minute4;
    logic [5:0] second4;
    logic       time_up4;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    timer #(.CLKS_PER_SEC(1)) dut1 (
        .SYSCLK  (clk),
        .RST_B   (rst),
        .TIME_MIN(tmin),
        .TIME_SEC(tsec),
        .START   (start),
        .MINUTE  (minute),
        .SECOND  (second),
        .TIME_UP (time_up)
    );

    timer #(.CLKS_PER_SEC(4)) dut4 (
        .SYSCLK  (clk),
        .RST_B   (rst),
        .TIME_MIN(tmin4),
        .TIME_SEC(tsec4),
        .START   (start4),
        .MINUTE  (minute4),
        .SECOND  (second4),
        .TIME_UP (time_up4)
    );

    task automatic addVec(input logic r, input logic st, input int tm, input int ts,
                          input int ed, input int em, input int es, input logic eu);
        vec_t v;
        v.rst = r;
        v.start = st;
        v.tmin = 3'(tm);
        v.tsec = 6'(ts);
        v.edges = ed;
        v.exp_min = 3'(em);
        v.exp_sec = 6'(es);
        v.exp_up = eu;
        vecs.push_back(v);
    endtask

    task automatic expect1(input string name, input int sel, input int m, input int s, input logic up);
        exp_t e;
        e.name = name;
        e.sel = sel;
        e.m = 3'(m);
        e.s = 6'(s);
        e.up = up;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [2:0] am;
        logic [5:0] as;
        logic       au;
        if (sb.size() == 0) begin
            n_miss++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        am = (e.sel == 4) ? minute4 : minute;
        as = (e.sel == 4) ? second4 : second;
        au = (e.sel == 4) ? time_up4 : time_up;
        n_vec++;
        if (am !== e.m || as !== e.s || au !== e.up) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d:%0d up=%0b, expected %0d:%0d up=%0b",
                     e.name, am, as, au, e.m, e.s, e.up);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
    task automatic applyStimulus(input vec_t v, input int idx);
        rst = v.rst;
        start = v.start;
        tmin = v.tmin;
        tsec = v.tsec;
        expect1($sformatf("vec%0d", idx), 1, int'(v.exp_min), int'(v.exp_sec), v.exp_up);
        if (v.edges == 0) begin
            #1;
        end else begin
            for (int i = 0; i < v.edges; i++) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rem;

        // rst start min sec edges -> min sec up
        addVec(1, 0, 0, 0,   1,  0, 0,  0);
        addVec(0, 1, 3, 48,  1,  3, 48, 0);
        addVec(0, 0, 0, 0,   1,  3, 47, 0);
        addVec(0, 0, 0, 0,   48, 2, 59, 0);
        addVec(0, 0, 0, 0,   179, 0, 0, 1);
        addVec(0, 0, 0, 0,   5,  0, 0,  1);
        addVec(0, 1, 0, 5,   1,  0, 5,  0);
        addVec(0, 0, 0, 0,   4,  0, 1,  0);
        addVec(0, 0, 0, 0,   1,  0, 0,  1);
        addVec(0, 1, 0, 0,   1,  0, 0,  0);
        addVec(0, 0, 0, 0,   1,  0, 0,  1);
        addVec(0, 0, 0, 0,   3,  0, 0,  1);
        addVec(0, 1, 7, 63,  1,  7, 59, 0);
        addVec(0, 0, 0, 0,   1,  7, 58, 0);
        addVec(1, 0, 0, 0,   0,  0, 0,  0);
        addVec(0, 0, 5, 5,   3,  0, 0,  0);
        addVec(0, 1, 2, 15,  1,  2, 15, 0);
        addVec(0, 0, 0, 0,   5,  2, 10, 0);
        addVec(0, 1, 0, 3,   1,  0, 3,  0);
        addVec(0, 0, 0, 0,   2,  0, 1,  0);
        addVec(0, 0, 0, 0,   1,  0, 0,  1);

        rst = 1'b1;
        #2;
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Asynchronous reset in the middle of a count, with START held during reset.
        start = 1'b1; tmin = 3'd1; tsec = 6'd20;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        expect1("midcount_1_10", 1, 1, 10, 1'b0);
        checkOutput();
        #3;
        rst = 1'b1;
        #1;
        expect1("async_reset", 1, 0, 0, 1'b0);
        checkOutput();
        n_vec++;
        if (dut1.state_q !== IDLE) begin
            n_miss++;
            $display("[TB] FAIL reset_state: got %0d, expected %0d", dut1.state_q, IDLE);
        end
        start = 1'b1; tmin = 3'd4; tsec = 6'd4;
        repeat (2) @(posedge clk);
        #1;
        expect1("start_in_reset", 1, 0, 0, 1'b0);
        checkOutput();
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect1("idle_hold", 1, 0, 0, 1'b0);
        checkOutput();
        start = 1'b1; tmin = 3'd2; tsec = 6'd2;
        @(posedge clk); #1; start = 1'b0;
        expect1("resume_load", 1, 2, 2, 1'b0);
        checkOutput();

        // Clamp plus prescaled ticking on the CLKS_PER_SEC=4 instance.
        start4 = 1'b1; tmin4 = 3'd1; tsec4 = 6'd63;
        @(posedge clk); #1; start4 = 1'b0;
        expect1("p4_load", 4, 1, 59, 1'b0);
        checkOutput();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            rem = 119 - k / 4;
            expect1($sformatf("p4_edge%0d", k), 4, rem / 60, rem % 60, 1'b0);
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter CLKS_PER_SEC, default 1, meaning SYSCLK cycles per one-second tick (legal values 1 and up).
REQ-002 SHALL have port SYSCLK  input  1  single clock; all registers update on its rising edge.
REQ-003 SHALL have port RST_B  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port TIME_MIN  input  3  preset minutes, 0..7.
REQ-005 SHALL have port TIME_SEC  input  6  preset seconds, 0..59.
REQ-006 SHALL have port START  input  1  load-and-run request, sampled at each rising edge.
REQ-007 SHALL have port MINUTE  output  3  remaining minutes, registered.
REQ-008 SHALL have port SECOND  output  6  remaining seconds, registered.
REQ-009 SHALL have port TIME_UP  output  1  expiry flag, registered.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 SHALL, in any state, when START=1 at an edge: load MINUTE<=TIME_MIN, SECOND<=min(TIME_SEC,59), clear TIME_UP, clear the prescaler, and enter RUN; a mid-run START restarts the count.
REQ-012 SHALL clamp any TIME_SEC value of 60..63 to 59 at load.
REQ-013 SHALL, in RUN, generate one tick every CLKS_PER_SEC cycles after load; the first tick comes CLKS_PER_SEC edges after the load edge.
REQ-014 SHALL, on a tick in RUN with SECOND>0: SECOND<=SECOND-1, MINUTE unchanged.
REQ-015 SHALL, on a tick in RUN with SECOND=0 and MINUTE>0: MINUTE<=MINUTE-1, SECOND<=59.
REQ-016 SHALL, on the tick that makes {MINUTE,SECOND} 0:00, assert TIME_UP on that same edge and enter DONE.
REQ-017 SHALL, on a tick in RUN with a loaded value of 0:00, assert TIME_UP and enter DONE, with MINUTE/SECOND staying 0.
REQ-018 SHALL hold MINUTE=0, SECOND=0 and TIME_UP=1 in DONE until START or reset; the count never wraps below 0:00.
REQ-019 SHALL hold MINUTE/SECOND and keep TIME_UP=0 in IDLE.
REQ-020 SHALL, with CLKS_PER_SEC=1 and a load of M:S at edge n, reach 0:00 with TIME_UP=1 at edge n+60*M+S (n+1 when M:S=0:00).
REQ-021 SHALL give START priority over a tick coinciding on the same edge.

Reset
REQ-022 SHALL, while RST_B=1, force MINUTE=0, SECOND=0, TIME_UP=0, prescaler=0 and state IDLE, independent of SYSCLK.
REQ-023 SHALL abort any countdown on reset mid-RUN and ignore START while RST_B=1.
REQ-024 SHALL resume normal operation at the first rising edge after RST_B deasserts.

Structure
REQ-025 SHALL place the state enumeration and the constant SEC_MAX=59 in shared package timer_pkg.
REQ-026 SHALL implement the prescaler as sub-module timer_tick_gen (inputs clk, rst, clr, en; output tick), with CLKS_PER_SEC=1 yielding tick=en.
REQ-027 SHALL keep the FSM and the minute/second down-counters in timer itself.

Verification
REQ-028 SHALL check: reset, then START pulse with 3:48, CLKS_PER_SEC=1 -> 3:47 one edge later, 2:59 after 49 edges, 0:00 with TIME_UP=1 after 228 edges, then held.
REQ-029 SHALL check: START with 0:00 -> TIME_UP=1 one edge later, outputs stay 0:00.
REQ-030 SHALL check: reset at mid-count 1:10 -> outputs 0:00, TIME_UP=0 immediately (asynchronous), state IDLE.
REQ-031 SHALL check: in DONE, START with 0:05 -> TIME_UP clears on the load edge, 0:00 and TIME_UP=1 five edges later.
REQ-032 SHALL check: TIME_SEC=63, TIME_MIN=1 -> loads 1:59; with CLKS_PER_SEC=4 each decrement arrives exactly 4 edges apart.
REQ-033 SHALL check: START reasserted at 2:10 with preset 0:03 -> restart at 0:03 and expiry 3 edges later.
